fragment_buffer_responder: RTL and testbench
============================================

FRAGMENT_BUFFER_RESPONDER -- requirements
Module: fragment_buffer_responder

Interface
REQ-001 SHALL have parameter FRAMEBUFFER_INDEX_WIDTH, default 14: address width; depth = 2**FRAMEBUFFER_INDEX_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width (color 32, depth 16, stencil 4).
REQ-003 SHALL use one clock and a synchronous, active-high reset: aclk  in  1  clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 s_raddr_tvalid  in  1  read request valid.
REQ-006 s_raddr_tready  out  1  read request accepted.
REQ-007 s_raddr_tindex  in  FRAMEBUFFER_INDEX_WIDTH  read address.
REQ-008 m_rvalid  out  1  read data valid; connects to the fragment pipeline's rvalid.
REQ-009 m_rready  in  1  read data consumed.
REQ-010 m_rdata  out  DATA_WIDTH  read data.
REQ-011 s_wvalid  in  1  write beat valid; no ready, always accepted.
REQ-012 s_waddr  in  FRAMEBUFFER_INDEX_WIDTH  write address.
REQ-013 s_wdata  in  DATA_WIDTH  write data.
REQ-014 s_wstrb  in  1  write enable qualifier; a beat with strb=0 is consumed without writing.
REQ-015 s_wlast  in  1  last beat of a primitive.
REQ-016 lastWritten  out  1  one-cycle pulse, one cycle after a beat with s_wvalid and s_wlast both high.
REQ-017 confClearColor  in  DATA_WIDTH  clear value.
REQ-018 clearStart  in  1  clear request pulse.
REQ-019 clearBusy  out  1  clear in progress.
REQ-020 clearDone  out  1  one-cycle pulse when a clear completes.

Function
REQ-021 SHALL hold the buffer in a 1-write/1-read synchronous RAM; contents are undefined after power-up.
REQ-022 SHALL accept a read on any cycle where s_raddr_tvalid and s_raddr_tready are both high.
REQ-023 SHALL buffer read responses in a 2-entry output FIFO; s_raddr_tready = (FIFO occupancy + reads in flight) < 2, and not clearBusy.
REQ-024 SHALL present the response for a read accepted in cycle N on m_rvalid/m_rdata in cycle N+1 when the FIFO is empty; responses stay in request order.
REQ-025 SHALL sustain one read per cycle while m_rready stays high.
REQ-026 SHALL hold m_rdata stable while m_rvalid=1 and m_rready=0.
REQ-027 SHALL write s_wdata to s_waddr when s_wvalid=1 and s_wstrb=1.
REQ-028 Same-cycle read and write to the same address with s_wstrb=1: read SHALL return the new s_wdata (write-first).
REQ-029 A write SHALL NOT update read data already in the output FIFO; ordering across the pipeline latency is the upstream's responsibility.
REQ-030 Clear FSM SHALL have states IDLE and CLEAR.
REQ-031 IDLE->CLEAR on clearStart=1; the clear counter is set to 0.
REQ-032 In CLEAR, SHALL write confClearColor to the counter address and increment the counter, one word per cycle.
REQ-033 In CLEAR, an s_wvalid&s_wstrb beat SHALL take the RAM write port; the clear write and the counter increment stall for that cycle.
REQ-034 After writing the last address (all ones), SHALL go CLEAR->IDLE, pulse clearDone for 1 cycle and drop clearBusy in that same cycle.
REQ-035 clearStart during CLEAR SHALL be ignored.
REQ-036 clearBusy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-037 A clear of depth D with no write collisions SHALL take D cycles from the cycle after clearStart.
REQ-038 During CLEAR, responses already queued SHALL still drain on m_rdata.

Reset
REQ-039 On reset SHALL force: FIFO empty, reads in flight discarded, m_rvalid=0, lastWritten=0, clearBusy=0, clearDone=0, FSM=IDLE, counter=0.
REQ-040 Reset during CLEAR SHALL abort the clear without a clearDone pulse; RAM contents are left partially cleared.
REQ-041 s_raddr_tready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-042 SHALL use the macro FRAGMENT_BUFFER_CLEAR_EN.
REQ-043 With FRAGMENT_BUFFER_CLEAR_EN defined, the clear FSM and counter SHALL be present as specified.
REQ-044 With FRAGMENT_BUFFER_CLEAR_EN undefined: no FSM or counter; clearStart and confClearColor ignored; clearBusy=0 and clearDone=0 constant; s_raddr_tready depends only on FIFO occupancy and reads in flight.

Verification
REQ-045 Write 0xDEADBEEF@5 with strb=1, then read 5 with m_rready=1 -> m_rdata=0xDEADBEEF one cycle after acceptance.
REQ-046 Write 0x11223344@7 with strb=0 over prior 0xAAAAAAAA -> read 7 returns 0xAAAAAAAA.
REQ-047 Same-cycle write 0x12345678@9 (strb=1) and read 9 -> m_rdata=0x12345678.
REQ-048 Hold m_rready=0, issue 3 reads (0,1,2) -> 2 accepted, s_raddr_tready=0 and m_rdata stable; release m_rready -> data for 0,1,2 delivered in order.
REQ-049 FRAMEBUFFER_INDEX_WIDTH=4, confClearColor=0xFF00FF00, clearStart -> clearBusy for 16 cycles, clearDone once, all 16 reads return 0xFF00FF00; with a write beat injected mid-clear -> 17 cycles, and the injected address ends with the value of whichever of the write or the clear reached it last.
REQ-050 Assert reset at clear counter=6 -> clearBusy=0, no clearDone, m_rvalid=0; build with FRAGMENT_BUFFER_CLEAR_EN undefined -> clearStart leaves clearBusy=0.

Source files
------------

// File: rtl/fragment_buffer_responder.sv
// fragment_buffer_responder: 1W/1R framebuffer RAM with write-first reads, 2-entry response FIFO
// and an optional fill-clear engine enabled by the macro FRAGMENT_BUFFER_CLEAR_EN.
module fragment_buffer_responder #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               aclk,
    input  logic                               reset,
    input  logic                               s_raddr_tvalid,
    output logic                               s_raddr_tready,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_raddr_tindex,
    output logic                               m_rvalid,
    input  logic                               m_rready,
    output logic [DATA_WIDTH-1:0]              m_rdata,
    input  logic                               s_wvalid,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_waddr,
    input  logic [DATA_WIDTH-1:0]              s_wdata,
    input  logic                               s_wstrb,
    input  logic                               s_wlast,
    output logic                               lastWritten,
    input  logic [DATA_WIDTH-1:0]              confClearColor,
    input  logic                               clearStart,
    output logic                               clearBusy,
    output logic                               clearDone
);
    localparam int DEPTH = 2 ** FRAMEBUFFER_INDEX_WIDTH;

    logic [DATA_WIDTH-1:0]              r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]              r_fifo [2];
    logic [DATA_WIDTH-1:0]              r_rd;
    logic [1:0]                         r_cnt;
    logic                               r_rp, r_wp, r_inflight, r_last;
    logic                               w_user_we, w_we, w_accept, w_pop, w_push, w_has_fifo;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] w_wa;
    logic [DATA_WIDTH-1:0]              w_wd;

    assign w_user_we = s_wvalid & s_wstrb;

`ifdef FRAGMENT_BUFFER_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                             r_state, w_next;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] r_ctr, w_ctr_next;
    logic                               r_done, w_done_next, w_clr_we;

    // A user write beat owns the RAM port; the clear simply waits a cycle.
    always_comb begin
        w_next = r_state;
        w_ctr_next = r_ctr;
        w_done_next = 1'b0;
        w_clr_we = 1'b0;
        if (r_state == IDLE && clearStart) begin
            w_next = CLEAR;
            w_ctr_next = '0;
        end else if (r_state == CLEAR && !w_user_we) begin
            w_clr_we = 1'b1;
            w_ctr_next = r_ctr + 1'b1;
            if (&r_ctr) begin
                w_next = IDLE;
                w_done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctr <= '0;
            r_done <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctr <= w_ctr_next;
            r_done <= w_done_next;
        end
    end

    assign w_we = w_user_we | w_clr_we;
    assign w_wa = w_user_we ? s_waddr : r_ctr;
    assign w_wd = w_user_we ? s_wdata : confClearColor;
    assign clearBusy = (r_state == CLEAR);
    assign clearDone = r_done;
`else
    logic w_unused;
    assign w_unused = ^{clearStart, confClearColor};
    assign w_we = w_user_we;
    assign w_wa = s_waddr;
    assign w_wd = s_wdata;
    assign clearBusy = 1'b0;
    assign clearDone = 1'b0;
`endif

    assign s_raddr_tready = ((r_cnt + {1'b0, r_inflight}) < 2'd2) && !clearBusy;
    assign w_accept = s_raddr_tvalid & s_raddr_tready;
    assign w_has_fifo = (r_cnt != 2'd0);
    assign m_rvalid = w_has_fifo | r_inflight;
    assign m_rdata = w_has_fifo ? r_fifo[r_rp] : r_rd;
    assign w_pop = w_has_fifo & m_rready;
    // Fresh RAM data bypasses the FIFO only when it is empty and the consumer is ready.
    assign w_push = r_inflight & (w_has_fifo | ~m_rready);

    always_ff @(posedge aclk) begin
        if (w_we)
            r_mem[w_wa] <= w_wd;
        if (w_accept)
            r_rd <= (w_we && w_wa == s_raddr_tindex) ? w_wd : r_mem[s_raddr_tindex];
        if (w_push)
            r_fifo[r_wp] <= r_rd;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_cnt <= 2'd0;
            r_rp <= 1'b0;
            r_wp <= 1'b0;
            r_inflight <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            r_rp <= r_rp ^ w_pop;
            r_wp <= r_wp ^ w_push;
            r_inflight <= w_accept;
            r_last <= s_wvalid & s_wlast;
        end
    end

    assign lastWritten = r_last;
endmodule

// File: tb/tb_fragment_buffer_responder.sv
// tb_fragment_buffer_responder: directed bench for fragment_buffer_responder with a 16-word buffer.
module tb_fragment_buffer_responder;
    logic        aclk, reset;
    logic        s_raddr_tvalid, s_raddr_tready, m_rvalid, m_rready;
    logic [3:0]  s_raddr_tindex, s_waddr;
    logic [31:0] m_rdata, s_wdata, confClearColor;
    logic        s_wvalid, s_wstrb, s_wlast, lastWritten, clearStart, clearBusy, clearDone;
    int          passed = 0;
    int          total = 0;

    fragment_buffer_responder #(.FRAMEBUFFER_INDEX_WIDTH(4), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .reset(reset),
        .s_raddr_tvalid(s_raddr_tvalid), .s_raddr_tready(s_raddr_tready), .s_raddr_tindex(s_raddr_tindex),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .lastWritten(lastWritten), .confClearColor(confClearColor), .clearStart(clearStart),
        .clearBusy(clearBusy), .clearDone(clearDone)
    );

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic strb);
        s_wvalid = 1; s_waddr = a; s_wdata = d; s_wstrb = strb;
        cyc();
        s_wvalid = 0; s_wstrb = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        total++; if (s_raddr_tready !== 1'b1) $display("FAIL rst_tready: got %b want 1", s_raddr_tready); else passed++;
        total++; if (m_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", m_rvalid); else passed++;
        total++; if (lastWritten !== 1'b0) $display("FAIL rst_last: got %b want 0", lastWritten); else passed++;
        total++; if ({clearBusy, clearDone} !== 2'b00) $display("FAIL rst_clear: got %b want 00", {clearBusy, clearDone}); else passed++;
    endtask

    task automatic test_write_read();
        wr(4'd5, 32'hDEADBEEF, 1);
        s_raddr_tvalid = 1; s_raddr_tindex = 5; m_rready = 1;
        cyc();
        s_raddr_tvalid = 0;
        total++; if (m_rvalid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", m_rvalid); else passed++;
        total++; if (m_rdata !== 32'hDEADBEEF) $display("FAIL wr_rd_data: got %h want deadbeef", m_rdata); else passed++;
        cyc();
        total++; if (m_rvalid !== 1'b0) $display("FAIL wr_rd_idle: got %b want 0", m_rvalid); else passed++;
    endtask

    task automatic test_strobe();
        wr(4'd7, 32'hAAAAAAAA, 1);
        wr(4'd7, 32'h11223344, 0);
        s_raddr_tvalid = 1; s_raddr_tindex = 7;
        cyc();
        s_raddr_tvalid = 0;
        total++; if (m_rdata !== 32'hAAAAAAAA) $display("FAIL strb0_data: got %h want aaaaaaaa", m_rdata); else passed++;
        cyc();
    endtask

    task automatic test_write_first();
        s_wvalid = 1; s_wstrb = 1; s_waddr = 9; s_wdata = 32'h12345678;
        s_raddr_tvalid = 1; s_raddr_tindex = 9;
        cyc();
        s_wvalid = 0; s_wstrb = 0; s_raddr_tvalid = 0;
        total++; if (m_rdata !== 32'h12345678) $display("FAIL wfirst_data: got %h want 12345678", m_rdata); else passed++;
        cyc();
    endtask

    task automatic test_last_written();
        s_wvalid = 1; s_wlast = 1; s_wstrb = 0;
        cyc();
        s_wvalid = 0;
        total++; if (lastWritten !== 1'b1) $display("FAIL last_pulse: got %b want 1", lastWritten); else passed++;
        cyc();
        total++; if (lastWritten !== 1'b0) $display("FAIL last_nowvalid: got %b want 0", lastWritten); else passed++;
        s_wlast = 0;
        cyc();
        total++; if (lastWritten !== 1'b0) $display("FAIL last_end: got %b want 0", lastWritten); else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) wr(4'(i), 32'h100 + i, 1);
        m_rready = 0; s_raddr_tvalid = 1; s_raddr_tindex = 0;
        total++; if (s_raddr_tready !== 1'b1) $display("FAIL bp_acc0: got %b want 1", s_raddr_tready); else passed++;
        cyc();
        s_raddr_tindex = 1;
        total++; if (s_raddr_tready !== 1'b1) $display("FAIL bp_acc1: got %b want 1", s_raddr_tready); else passed++;
        cyc();
        s_raddr_tindex = 2;
        total++; if (s_raddr_tready !== 1'b0) $display("FAIL bp_full: got %b want 0", s_raddr_tready); else passed++;
        cyc();
        total++; if (m_rdata !== 32'h100 || m_rvalid !== 1'b1) $display("FAIL bp_hold1: got %h/%b want 100/1", m_rdata, m_rvalid); else passed++;
        cyc();
        total++; if (m_rdata !== 32'h100 || s_raddr_tready !== 1'b0) $display("FAIL bp_hold2: got %h/%b want 100/0", m_rdata, s_raddr_tready); else passed++;
        m_rready = 1;
        cyc();
        total++; if (m_rdata !== 32'h101 || s_raddr_tready !== 1'b1) $display("FAIL bp_d1: got %h/%b want 101/1", m_rdata, s_raddr_tready); else passed++;
        cyc();
        s_raddr_tvalid = 0;
        total++; if (m_rdata !== 32'h102 || m_rvalid !== 1'b1) $display("FAIL bp_d2: got %h/%b want 102/1", m_rdata, m_rvalid); else passed++;
        cyc();
        total++; if (m_rvalid !== 1'b0) $display("FAIL bp_empty: got %b want 0", m_rvalid); else passed++;
    endtask

    task automatic test_back_to_back();
        m_rready = 1; s_raddr_tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            s_raddr_tindex = 4'(i);
            cyc();
            total++; if (m_rdata !== 32'h100 + i || s_raddr_tready !== 1'b1) $display("FAIL b2b_%0d: got %h/%b want %h/1", i, m_rdata, s_raddr_tready, 32'h100 + i); else passed++;
        end
        s_raddr_tvalid = 0;
        cyc();
    endtask

`ifdef FRAGMENT_BUFFER_CLEAR_EN
    task automatic test_clear(input bit inject);
        int busy = 0;
        int done = 0;
        int bad = 0;
        confClearColor = 32'hFF00FF00;
        clearStart = 1;
        cyc();
        clearStart = 0;
        for (int k = 0; k < 40; k++) begin
            if (inject && k == 2) begin
                s_wvalid = 1; s_wstrb = 1; s_waddr = 1; s_wdata = 32'h0BADF00D;
            end else begin
                s_wvalid = 0; s_wstrb = 0;
            end
            if (clearBusy) busy++;
            if (clearDone) begin
                done++;
                if (clearBusy) bad++;
            end
            cyc();
        end
        total++; if (busy !== (inject ? 17 : 16)) $display("FAIL clr_busy_cycles: got %0d want %0d", busy, inject ? 17 : 16); else passed++;
        total++; if (done !== 1 || bad !== 0) $display("FAIL clr_done: got %0d pulses (%0d overlapping busy) want 1 (0)", done, bad); else passed++;
        m_rready = 1; s_raddr_tvalid = 1;
        for (int i = 0; i < 16; i++) begin
            s_raddr_tindex = 4'(i);
            cyc();
            total++; if (m_rdata !== ((inject && i == 1) ? 32'h0BADF00D : 32'hFF00FF00)) $display("FAIL clr_rd_%0d: got %h", i, m_rdata); else passed++;
        end
        s_raddr_tvalid = 0;
        cyc();
    endtask

    task automatic test_clear_reset();
        int done = 0;
        m_rready = 0; s_raddr_tvalid = 1; s_raddr_tindex = 3;
        cyc();
        s_raddr_tvalid = 0; clearStart = 1;
        cyc();
        clearStart = 0;
        for (int k = 0; k < 6; k++) cyc();
        total++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hFF00FF00 || clearBusy !== 1'b1) $display("FAIL clr_queued: got %b/%h/%b want 1/ff00ff00/1", m_rvalid, m_rdata, clearBusy); else passed++;
        reset = 1;
        cyc();
        reset = 0;
        total++; if ({clearBusy, clearDone, m_rvalid} !== 3'b000) $display("FAIL clr_abort: got %b want 000", {clearBusy, clearDone, m_rvalid}); else passed++;
        for (int k = 0; k < 20; k++) begin
            if (clearDone || clearBusy) done++;
            cyc();
        end
        total++; if (done !== 0) $display("FAIL clr_abort_quiet: got %0d active cycles want 0", done); else passed++;
    endtask
`else
    task automatic test_clear_disabled();
        int act = 0;
        confClearColor = 32'hFF00FF00;
        clearStart = 1;
        cyc();
        clearStart = 0;
        for (int k = 0; k < 20; k++) begin
            if (clearBusy || clearDone || !s_raddr_tready) act++;
            cyc();
        end
        total++; if (act !== 0) $display("FAIL noclr_quiet: got %0d active cycles want 0", act); else passed++;
        s_raddr_tvalid = 1; s_raddr_tindex = 5; m_rready = 1;
        cyc();
        s_raddr_tvalid = 0;
        total++; if (m_rdata !== 32'hDEADBEEF) $display("FAIL noclr_data: got %h want deadbeef", m_rdata); else passed++;
        cyc();
    endtask
`endif

    initial begin
        reset = 1; s_raddr_tvalid = 0; s_raddr_tindex = 0; m_rready = 0;
        s_wvalid = 0; s_waddr = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
        confClearColor = 0; clearStart = 0;
        test_reset();
        test_write_read();
        test_strobe();
        test_write_first();
        test_last_written();
        test_backpressure();
        test_back_to_back();
`ifdef FRAGMENT_BUFFER_CLEAR_EN
        test_clear(0);
        test_clear(1);
        test_clear_reset();
`else
        test_clear_disabled();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
